// File: rtl/clk_mode_pkg.sv
// Shared encodings and defaults for the front-panel clock mode controller.
package clk_mode_pkg;

  typedef enum logic [1:0] {
    MODE_SLOW = 2'b00,
    MODE_FAST = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  // 20 ms of stable samples at the 50 MHz board oscillator
  localparam int DB_CYCLES_DEF   = 1000000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_mode_if.sv
// Front-panel buttons in, divider/gating controls out.
interface clk_mode_if;
  logic       btn_mode;
  logic       btn_step;
  logic       choose;
  logic       halt;
  logic       step_pulse;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_step,
    input  choose, halt, step_pulse, mode
  );

  modport slave (
    input  btn_mode, btn_step,
    output choose, halt, step_pulse, mode
  );
endinterface

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press strobe: synchronizer, stability counter,
// registered rising-edge detect on the debounced level.
module btn_debounce
  import clk_mode_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_press
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   db;
  logic                   db_q;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      db        <= 1'b0;
      db_q      <= 1'b0;
      cnt       <= '0;
      btn_press <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_raw};
      // Any sample agreeing with the accepted level restarts the count
      if (sync[SYNC_STAGES-1] == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      db_q      <= db;
      btn_press <= db & ~db_q;
    end
  end

endmodule

// File: rtl/clk_mode_ctrl.sv
// Run-mode controller ahead of the CPU clock divider: SLOW -> FAST -> STEP,
// with debounced buttons and single-cycle step pulses while halted.
module clk_mode_ctrl
  import clk_mode_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n,
  clk_mode_if.slave   bus
);

  logic  mode_press;
  logic  step_press;
  mode_e state;
  logic  choose_q;
  logic  halt_q;
  logic  step_pulse_q;
  logic [1:0] mode_q;

  btn_debounce #(
    .DB_CYCLES   (DB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_db_mode (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .btn_raw   (bus.btn_mode),
    .btn_press (mode_press)
  );

  btn_debounce #(
    .DB_CYCLES   (DB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_db_step (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .btn_raw   (bus.btn_step),
    .btn_press (step_press)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MODE_SLOW;
      choose_q     <= 1'b0;
      halt_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      mode_q       <= 2'b00;
    end else begin
      // A mode press in the same cycle swallows the step press
      step_pulse_q <= step_press && !mode_press && (state == MODE_STEP);
      case (state)
        MODE_SLOW: if (mode_press) state <= MODE_FAST;
        MODE_FAST: if (mode_press) state <= MODE_STEP;
        MODE_STEP: if (mode_press) state <= MODE_SLOW;
        default:   state <= MODE_SLOW;
      endcase
      choose_q <= (state == MODE_FAST);
      halt_q   <= (state == MODE_STEP);
      mode_q   <= state;
    end
  end

  assign bus.choose     = choose_q;
  assign bus.halt       = halt_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.mode       = mode_q;

endmodule
